// File: rtl/pc_gen_pkg.sv
// Shared encodings for the fetch-stage PC generator: FSM states, jump codes
// and the B-type funct3 values.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b10;
  localparam logic [1:0] JUMP_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_gen_br_cond.sv
// Branch-condition decode: funct3 plus ALU compare flags -> taken.
// Reserved funct3 values (010/011) are never taken.
module pc_gen_br_cond
  import pc_gen_pkg::*;
(
  input  logic [2:0] br_op_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (br_op_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = ~zero_i;
      F3_BLT:  taken_o = lt_i;
      F3_BGE:  taken_o = ~lt_i;
      F3_BLTU: taken_o = ltu_i;
      F3_BGEU: taken_o = ~ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// RV32 fetch-stage program counter: sequential / branch / JAL / JALR next-PC,
// stall, one-cycle boot, misaligned-target trap and a retired-fetch counter.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IMM_W     = 21,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned TRAP_VEC  = 'h3C0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       br_op,
  input  logic             zero_flag,
  input  logic             lt_flag,
  input  logic             ltu_flag,
  input  logic [1:0]       jump_mode,
  input  logic [IMM_W-1:0] immediate,
  input  logic [XLEN-1:0]  reg_out1,
  input  logic             trap_clear,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  pc_plus4,
  output logic             fetch_valid,
  output logic             redirect,
  output logic             misalign_fault,
  output logic [PC_W-1:0]  fault_pc,
  output logic [CNT_W-1:0] fetch_count,
  output state_e           state_dbg
);

  localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] TRAP_PC = PC_W'(TRAP_VEC);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_q, redirect_d;

  logic             taken;
  logic             nonseq;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_rel;
  logic [PC_W-1:0]  jalr_sum;

  // Targets are reduced mod 2^PC_W, so only the low PC_W bits of the
  // sign-extended immediate and rs1 ever matter (IMM_W, XLEN >= PC_W).
  logic unused_hi;
  assign unused_hi = ^{reg_out1[XLEN-1:PC_W], immediate[IMM_W-1:PC_W]};

  pc_gen_br_cond u_br_cond (
    .br_op_i (br_op),
    .zero_i  (zero_flag),
    .lt_i    (lt_flag),
    .ltu_i   (ltu_flag),
    .taken_o (taken)
  );

  assign pc_rel   = pc_q + immediate[PC_W-1:0];
  assign jalr_sum = reg_out1[PC_W-1:0] + immediate[PC_W-1:0];
  assign pc_plus4 = pc_q + PC_W'(4);

  always_comb begin
    nonseq = 1'b0;
    target = pc_rel;
    if (jump_mode == JUMP_JALR) begin
      nonseq = 1'b1;
      target = {jalr_sum[PC_W-1:1], 1'b0};
    end else if (jump_mode == JUMP_JAL) begin
      nonseq = 1'b1;
    end else if (branch && taken) begin
      nonseq = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!nonseq) begin
            pc_d = pc_plus4;
          end else if (target[1:0] != 2'b00) begin
            // Faulting target is dropped; the faulting instruction's PC is kept.
            pc_d    = TRAP_PC;
            fault_d = pc_q;
            state_d = ST_TRAP;
          end else begin
            pc_d       = target;
            redirect_d = 1'b1;
          end
        end
      end
      ST_TRAP: if (trap_clear) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RST_PC;
      fault_q    <= '0;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_out         = pc_q;
  assign fetch_valid    = (state_q == ST_RUN);
  assign misalign_fault = (state_q == ST_TRAP);
  assign redirect       = redirect_q;
  assign fault_pc       = fault_q;
  assign fetch_count    = cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed walk through the key scenarios, then random
// stimulus checked each cycle against an integer-arithmetic reference model.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [2:0]  br_op;
  logic        zero_flag;
  logic        lt_flag;
  logic        ltu_flag;
  logic [1:0]  jump_mode;
  logic [20:0] immediate;
  logic [31:0] reg_out1;
  logic        trap_clear;
  logic [9:0]  pc_out;
  logic [9:0]  pc_plus4;
  logic        fetch_valid;
  logic        redirect;
  logic        misalign_fault;
  logic [9:0]  fault_pc;
  logic [15:0] fetch_count;
  state_e      state_dbg;

  pc_gen #(
    .PC_W(10), .XLEN(32), .IMM_W(21), .RESET_VEC(0), .TRAP_VEC('h3C0), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .br_op(br_op),
    .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag),
    .jump_mode(jump_mode), .immediate(immediate), .reg_out1(reg_out1),
    .trap_clear(trap_clear), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .redirect(redirect),
    .misalign_fault(misalign_fault), .fault_pc(fault_pc),
    .fetch_count(fetch_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // reference model: mode 0 boot, 1 run, 2 trap
  int m_mode, m_pc, m_fault, m_cnt;
  bit m_redir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_taken(input int op, input bit z, input bit l, input bit lu);
    case (op)
      0: return z;
      1: return !z;
      4: return l;
      5: return !l;
      6: return lu;
      7: return !lu;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_fault = 0; m_cnt = 0; m_redir = 0;
    exp_q.delete();
    exp_q.push_back(32'(m_pc));
  endtask

  task automatic model_step();
    int simm, tgt;
    bit jump;
    simm = int'($signed(immediate));
    m_redir = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (trap_clear) m_mode = 1;
    end else if (!stall) begin
      m_cnt = (m_cnt + 1) % 65536;
      jump = 1;
      if (jump_mode == 2'b11)
        tgt = int'((longint'(reg_out1) + longint'(simm)) & 1022);
      else if (jump_mode == 2'b10 || (branch && model_taken(int'(br_op), zero_flag, lt_flag, ltu_flag)))
        tgt = (m_pc + simm) & 1023;
      else begin
        jump = 0;
        tgt = (m_pc + 4) % 1024;
      end
      if (jump && (tgt % 4) != 0) begin
        m_fault = m_pc;
        m_pc = 'h3C0;
        m_mode = 2;
      end else begin
        m_pc = tgt;
        m_redir = jump;
      end
    end
    exp_q.push_back(32'(m_pc));
  endtask

  // One clock: compare all outputs at the falling edge, advance the model,
  // return just after the rising edge.
  task automatic step();
    logic [31:0] exp_pc;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      exp_pc = 32'(m_pc);
    end else begin
      exp_pc = exp_q.pop_front();
    end
    check("pc_out", 32'(pc_out), exp_pc);
    check("pc_plus4", 32'(pc_plus4), 32'((m_pc + 4) % 1024));
    check("fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
    check("misalign_fault", 32'(misalign_fault), 32'(m_mode == 2));
    check("redirect", 32'(redirect), 32'(m_redir));
    check("fault_pc", 32'(fault_pc), 32'(m_fault));
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit br, input int op, input bit z, input bit l,
                       input bit lu, input int jm, input int imm, input int r1, input bit tc);
    stall = st; branch = br; br_op = 3'(op); zero_flag = z; lt_flag = l; ltu_flag = lu;
    jump_mode = 2'(jm); immediate = 21'(imm); reg_out1 = 32'(r1); trap_clear = tc;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Drop reset mid-cycle and check that outputs clear before the next edge.
  task automatic async_reset_check(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_pc"}, 32'(pc_out), 32'd0);
    check({tag, "_valid"}, 32'(fetch_valid), 32'd0);
    check({tag, "_fault"}, 32'(misalign_fault), 32'd0);
    check({tag, "_fault_pc"}, 32'(fault_pc), 32'd0);
    check({tag, "_cnt"}, 32'(fetch_count), 32'd0);
    check({tag, "_redir"}, 32'(redirect), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive_random();
    int imm, r1;
    if ($urandom_range(0, 99) < 85) imm = (int'($urandom_range(0, 1023)) - 512) * 4;
    else imm = int'($urandom_range(0, 2097151));
    r1 = int'($urandom);
    if ($urandom_range(0, 99) < 80) r1 = r1 & ~3;
    drive($urandom_range(0, 99) < 20, $urandom_range(0, 1), int'($urandom_range(0, 7)),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 99) < 60) ? 0 : int'($urandom_range(2, 3)), imm, r1,
          $urandom_range(0, 99) < 40);
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // boot cycle then sequential fetch
    step();
    repeat (3) step();
    check("seq_pc12", 32'(pc_out), 32'd12);

    // beq taken, then blt not taken
    drive(0, 1, 0, 1, 0, 0, 0, 196, 0, 0);
    step();
    check("beq_pc", 32'(pc_out), 32'd208);
    check("beq_redirect", 32'(redirect), 32'd1);
    drive(0, 1, 4, 0, 0, 0, 0, 196, 0, 0);
    step();
    check("blt_nt_pc", 32'(pc_out), 32'd212);

    // JAL with wrap-free large offset
    drive(0, 0, 0, 0, 0, 0, 2, 800, 0, 0);
    check("jal_link", 32'(pc_plus4), 32'd216);
    step();
    check("jal_pc", 32'(pc_out), 32'd1012);

    // JALR to misaligned target traps
    drive(0, 0, 0, 0, 0, 0, 3, 20, 15, 0);
    step();
    check("trap_pc", 32'(pc_out), 32'h3C0);
    check("trap_fault_pc", 32'(fault_pc), 32'd1012);
    check("trap_fault", 32'(misalign_fault), 32'd1);
    drive(0, 1, 0, 1, 0, 0, 2, 8, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check("trap_exit_valid", 32'(fetch_valid), 32'd1);
    check("trap_exit_pc", 32'(pc_out), 32'h3C0);

    // stall beats a taken branch, then sequential wrap at 1020
    drive(1, 1, 0, 1, 0, 0, 0, 8, 0, 0);
    repeat (2) step();
    check("stall_pc", 32'(pc_out), 32'h3C0);
    drive_idle();
    repeat (15) step();
    check("wrap_pre", 32'(pc_out), 32'd1020);
    step();
    check("wrap_pc", 32'(pc_out), 32'd0);

    // enter trap via misaligned JAL, then async reset inside it
    drive(0, 0, 0, 0, 0, 0, 2, 2, 0, 0);
    step();
    check("trap2_fault", 32'(misalign_fault), 32'd1);
    drive_idle();
    async_reset_check("rst_trap");

    // randomized traffic with occasional async resets
    for (int i = 0; i < 600; i++) begin
      drive_random();
      if ($urandom_range(0, 199) == 0) async_reset_check("rst_rand");
      else step();
    end
    drive_idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
